// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes opcode/funct and sequences the ALU, memory and
// register-file strobes, counting retired instructions.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | FETCH  : read instruction at PC, PC += 4 when memory is ready
//   1   | DECODE : precompute branch target, dispatch on opcode
//   2   | MEMADR : compute lw/sw effective address
//   3   | MEMRD  : load data read, wait for memory
//   4   | MEMWB  : write loaded word to rt
//   5   | MEMWR  : store data write, wait for memory
//   6   | EXEC   : R-type ALU operation
//   7   | ALUWB  : write R-type result to rd
//   8   | BRANCH : beq compare, PC <= ALUOut when equal
//   9   | ADDIEX : addi ALU operation
//  10   | ADDIWB : write addi result to rt
//  11   | JUMP   : PC <= jump target
module mips_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_select,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       retire;
    logic       set_illegal;
    logic [3:0] funct_sel;
    logic       funct_ok;

    always_comb begin
        funct_ok  = 1'b1;
        funct_sel = ALU_ADD;
        case (funct)
            6'h20:   funct_sel = ALU_ADD;
            6'h22:   funct_sel = ALU_SUB;
            6'h24:   funct_sel = ALU_AND;
            6'h25:   funct_sel = ALU_OR;
            6'h2A:   funct_sel = ALU_SLT;
            6'h27:   funct_sel = ALU_NOR;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired <= retired + CNT_W'(1);
            if (set_illegal)
                illegal_op <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h00:        state_d = S_EXEC;
                    6'h04:        state_d = S_BRANCH;
                    6'h08:        state_d = S_ADDIEX;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                if (funct_ok) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d     = S_FETCH;
                    set_illegal = 1'b1;
                end
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_select = ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                alu_select = ALU_ADD;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_select = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_select = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_select = funct_sel;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_select = ALU_SUB;
                pc_src     = 2'b01;
                pc_write   = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Strobes stay quiet while reset is held, whatever the state register holds.
        if (!rst_n) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_select = ALU_ADD;
        end
    end

    assign state = state_q;

endmodule
